ddsv2_phase_accum: RTL and testbench

- DDS phase-generation stage that sits directly downstream of the AXI4-Lite DDS properties register block and consumes its configuration outputs.
- Each enabled cycle it advances a phase accumulator by the frequency tuning word and adds a phase offset.
- It emits the truncated phase as an AXI4-Stream toward the sine LUT / amplitude stage.
- Supports continuous mode and fixed-length burst mode, with shadowed (atomic) configuration updates.

---
 rtl/ddsv2_phase_accum.sv | 157 +++++++++++++++
 tb/tb_ddsv2_phase_accum.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddsv2_phase_accum.sv
// DDS phase accumulator with shadowed config, continuous/burst modes, AXI4-Stream phase output.
// One beat per cycle when downstream is ready; a stalled beat holds data, accumulator and counter.
module ddsv2_phase_accum #(
   parameter int ACC_W = 32,
   parameter int OUT_W = 16,
   parameter int CNT_W = 16
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic [ACC_W-1:0] cfg_ftw,
   input  logic [ACC_W-1:0] cfg_poff,
   input  logic [CNT_W-1:0] cfg_burst_len,
   input  logic             cfg_enable,
   input  logic             cfg_burst,
   input  logic             cfg_update,
   input  logic             cfg_clear,
   output logic [OUT_W-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sample_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [ACC_W-1:0] sh_ftw_q, sh_poff_q;
   logic [CNT_W-1:0] sh_len_q;
   logic             sh_en_q, sh_burst_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] tdata_q, tdata_d;
   logic             tvalid_q, tvalid_d;
   logic             tlast_q, tlast_d;
   logic             done_q, done_d;

   logic             active;
   logic             hs;
   logic             slot_free;
   logic             exhausted;
   logic             gen;
   logic [CNT_W-1:0] len_m1;

   assign active    = (state_q == S_RUN) || (state_q == S_BURST);
   assign hs        = tvalid_q && m_axis_tready;
   assign slot_free = !tvalid_q || m_axis_tready;
   assign exhausted = (state_q == S_BURST) && (cnt_q == sh_len_q);
   assign len_m1    = sh_len_q - CNT_ONE;
   // Generation also requires the shadowed enable so a disable never launches a fresh beat.
   assign gen       = active && sh_en_q && slot_free && !exhausted;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      done_d   = done_q;

      if (hs) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end
      if (gen) begin
         tdata_d  = OUT_W'((acc_q + sh_poff_q) >> (ACC_W - OUT_W));
         acc_d    = acc_q + sh_ftw_q;
         tvalid_d = 1'b1;
         cnt_d    = cnt_q + CNT_ONE;
         tlast_d  = (state_q == S_BURST) && (cnt_q == len_m1);
      end

      case (state_q)
         S_IDLE: begin
            if (sh_en_q) begin
               if (!sh_burst_q) begin
                  state_d = S_RUN;
               end else if (sh_len_q != '0) begin
                  state_d = S_BURST;
                  cnt_d   = '0;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (!sh_en_q && slot_free) state_d = S_IDLE;
         end
         S_BURST: begin
            // A clear restarts the burst, so the old final beat no longer completes it.
            if (hs && tlast_q && !cfg_clear) state_d = S_DONE;
            else if (!sh_en_q && slot_free) state_d = S_IDLE;
         end
         S_DONE: begin
            if (cfg_update || cfg_clear) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (cfg_clear) begin
         acc_d  = '0;
         cnt_d  = '0;
         done_d = 1'b0;
      end
      if (state_d == S_DONE && state_q != S_DONE) done_d = 1'b1;
      if (state_q == S_DONE && state_d != S_DONE) done_d = 1'b0;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q    <= S_IDLE;
         sh_ftw_q   <= '0;
         sh_poff_q  <= '0;
         sh_len_q   <= '0;
         sh_en_q    <= 1'b0;
         sh_burst_q <= 1'b0;
         acc_q      <= '0;
         cnt_q      <= '0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         if (cfg_update) begin
            sh_ftw_q   <= cfg_ftw;
            sh_poff_q  <= cfg_poff;
            sh_len_q   <= cfg_burst_len;
            sh_en_q    <= cfg_enable;
            sh_burst_q <= cfg_burst;
         end
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         done_q   <= done_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign busy          = active || tvalid_q;
   assign done          = done_q;
   assign sample_cnt    = cnt_q;

endmodule

// File: tb/tb_ddsv2_phase_accum.sv
// Bench for ddsv2_phase_accum: directed scenarios plus randomized runs against a phase-arithmetic model.
module tb_ddsv2_phase_accum;

   logic        ACLK;
   logic        ARESET;
   logic [31:0] cfg_ftw;
   logic [31:0] cfg_poff;
   logic [15:0] cfg_burst_len;
   logic        cfg_enable;
   logic        cfg_burst;
   logic        cfg_update;
   logic        cfg_clear;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        busy;
   logic        done;
   logic [15:0] sample_cnt;

   ddsv2_phase_accum #(.ACC_W(32), .OUT_W(16), .CNT_W(16)) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .cfg_ftw       (cfg_ftw),
      .cfg_poff      (cfg_poff),
      .cfg_burst_len (cfg_burst_len),
      .cfg_enable    (cfg_enable),
      .cfg_burst     (cfg_burst),
      .cfg_update    (cfg_update),
      .cfg_clear     (cfg_clear),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy),
      .done          (done),
      .sample_cnt    (sample_cnt)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [15:0] d;
      logic        l;
   } beat_t;

   int    n_tests = 0;
   int    n_fail  = 0;
   beat_t got[$];

   // Expected phase of the i-th beat after a clear: top 16 bits of i*ftw + poff.
   function automatic logic [15:0] ref_phase(input logic [31:0] ftw, input logic [31:0] poff, input int i);
      logic [31:0] ii;
      logic [31:0] a;
      ii = 32'(i);
      a  = ftw * ii + poff;
      return a[31:16];
   endfunction

   // Records a beat if it is accepted at the coming edge, then moves to just after that edge.
   task automatic clk_step();
      beat_t b;
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
         b.d = m_axis_tdata;
         b.l = m_axis_tlast;
         got.push_back(b);
      end
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset();
      cfg_ftw = '0; cfg_poff = '0; cfg_burst_len = '0;
      cfg_enable = 1'b0; cfg_burst = 1'b0; cfg_update = 1'b0; cfg_clear = 1'b0;
      m_axis_tready = 1'b0;
      ARESET = 1'b1;
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      @(posedge ACLK);
      #1;
      got.delete();
   endtask

   task automatic do_update(input logic [31:0] ftw, input logic [31:0] poff, input logic [15:0] len,
                            input logic en, input logic bst);
      cfg_ftw = ftw; cfg_poff = poff; cfg_burst_len = len; cfg_enable = en; cfg_burst = bst;
      cfg_update = 1'b1;
      clk_step();
      cfg_update = 1'b0;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      cfg_ftw = '0; cfg_poff = '0; cfg_burst_len = '0;
      cfg_enable = 1'b0; cfg_burst = 1'b0; cfg_update = 1'b0; cfg_clear = 1'b0;
      m_axis_tready = 1'b0;
      #12;
      n_tests++;
      if ({m_axis_tvalid, m_axis_tlast, busy, done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got v/l/busy/done=%b required 0000", {m_axis_tvalid, m_axis_tlast, busy, done});
      end
      n_tests++;
      if (m_axis_tdata !== 16'h0 || sample_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_data: got tdata=%h cnt=%0d required 0/0", m_axis_tdata, sample_cnt);
      end
      do_reset();
      m_axis_tready = 1'b1;
      repeat (4) clk_step();
      n_tests++;
      if (got.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got beats=%0d busy=%b required 0/0", got.size(), busy);
      end
   endtask

   task automatic test_continuous();
      logic [15:0] exp_c [5];
      exp_c = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000};
      do_reset();
      m_axis_tready = 1'b1;
      do_update(32'h4000_0000, 32'h0, 16'd0, 1'b1, 1'b0);
      n_tests++;
      if (m_axis_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL cont_latency0: got tvalid=%b required 0", m_axis_tvalid);
      end
      clk_step();
      n_tests++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL cont_latency1: got tvalid=%b busy=%b required 0/1", m_axis_tvalid, busy);
      end
      clk_step();
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_c[k] || m_axis_tlast !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_beat%0d: got v=%b d=%h l=%b busy=%b required 1/%h/0/1",
                     k, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, exp_c[k]);
         end
         clk_step();
      end
   endtask

   task automatic test_offset_retune();
      logic [15:0] exp_r [8];
      int guard;
      exp_r = '{16'h8000, 16'h9000, 16'hA000, 16'hB000, 16'hC000, 16'hE000, 16'h0000, 16'h2000};
      do_reset();
      m_axis_tready = 1'b1;
      do_update(32'h1000_0000, 32'h8000_0000, 16'd0, 1'b1, 1'b0);
      clk_step();
      clk_step();
      clk_step();
      clk_step();
      // 0x8000, 0x9000 accepted, 0xA000 now presented; retune takes effect from the gen after the update edge.
      do_update(32'h2000_0000, 32'h8000_0000, 16'd0, 1'b1, 1'b0);
      guard = 0;
      while (got.size() < 8 && guard < 30) begin
         clk_step();
         guard++;
      end
      n_tests++;
      if (got.size() < 8) begin
         n_fail++;
         $display("FAIL retune_timeout: got %0d beats required 8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (got[i].d !== exp_r[i]) begin
               n_fail++;
               $display("FAIL retune_beat%0d: got %h required %h", i, got[i].d, exp_r[i]);
            end
         end
      end
   endtask

   task automatic test_burst();
      int guard;
      do_reset();
      m_axis_tready = 1'b1;
      do_update(32'h0100_0000, 32'h0, 16'd4, 1'b1, 1'b1);
      guard = 0;
      while (done !== 1'b1 && guard < 30) begin
         clk_step();
         guard++;
      end
      repeat (3) clk_step();
      n_tests++;
      if (got.size() != 4) begin
         n_fail++;
         $display("FAIL burst_count: got %0d beats required 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got[i].d !== ref_phase(32'h0100_0000, 32'h0, i) || got[i].l !== (i == 3)) begin
               n_fail++;
               $display("FAIL burst_beat%0d: got d=%h l=%b required %h/%b",
                        i, got[i].d, got[i].l, ref_phase(32'h0100_0000, 32'h0, i), (i == 3));
            end
         end
      end
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0 || sample_cnt !== 16'd4 || m_axis_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL burst_end: got done=%b busy=%b cnt=%0d v=%b required 1/0/4/0",
                  done, busy, sample_cnt, m_axis_tvalid);
      end
      do_update(32'h0100_0000, 32'h0, 16'd4, 1'b0, 1'b1);
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL burst_done_clear: got done=%b required 0", done);
      end
   endtask

   task automatic test_backpressure();
      int guard;
      do_reset();
      m_axis_tready = 1'b1;
      do_update(32'h0100_0000, 32'h0, 16'd0, 1'b1, 1'b0);
      guard = 0;
      while (got.size() < 1 && guard < 20) begin
         clk_step();
         guard++;
      end
      m_axis_tready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         clk_step();
         n_tests++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0100 || sample_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got v=%b d=%h cnt=%0d required 1/0100/2",
                     c, m_axis_tvalid, m_axis_tdata, sample_cnt);
         end
      end
      m_axis_tready = 1'b1;
      guard = 0;
      while (got.size() < 6 && guard < 20) begin
         clk_step();
         guard++;
      end
      n_tests++;
      if (got.size() < 6) begin
         n_fail++;
         $display("FAIL bp_timeout: got %0d beats required 6", got.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (got[i].d !== ref_phase(32'h0100_0000, 32'h0, i)) begin
               n_fail++;
               $display("FAIL bp_beat%0d: got %h required %h", i, got[i].d, ref_phase(32'h0100_0000, 32'h0, i));
            end
         end
      end
   endtask

   task automatic test_clear_stalled();
      int guard;
      do_reset();
      m_axis_tready = 1'b1;
      do_update(32'h0100_0000, 32'h0050_0000, 16'd0, 1'b1, 1'b0);
      guard = 0;
      while (got.size() < 3 && guard < 20) begin
         clk_step();
         guard++;
      end
      m_axis_tready = 1'b0;
      n_tests++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0350) begin
         n_fail++;
         $display("FAIL clr_pending: got v=%b d=%h required 1/0350", m_axis_tvalid, m_axis_tdata);
      end
      cfg_clear = 1'b1;
      clk_step();
      cfg_clear = 1'b0;
      n_tests++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0350 || sample_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL clr_hold: got v=%b d=%h cnt=%0d required 1/0350/0", m_axis_tvalid, m_axis_tdata, sample_cnt);
      end
      m_axis_tready = 1'b1;
      clk_step();
      n_tests++;
      if (got.size() != 4 || got[got.size()-1].d !== 16'h0350) begin
         n_fail++;
         $display("FAIL clr_delivered: got n=%0d last=%h required 4/0350", got.size(), got[got.size()-1].d);
      end
      n_tests++;
      if (m_axis_tdata !== 16'h0050 || sample_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL clr_restart: got d=%h cnt=%0d required 0050/1", m_axis_tdata, sample_cnt);
      end
      clk_step();
      n_tests++;
      if (m_axis_tdata !== 16'h0150 || sample_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL clr_next: got d=%h cnt=%0d required 0150/2", m_axis_tdata, sample_cnt);
      end
   endtask

   task automatic test_burst_len0();
      do_reset();
      m_axis_tready = 1'b1;
      do_update(32'h0100_0000, 32'h0, 16'd0, 1'b1, 1'b1);
      repeat (5) clk_step();
      n_tests++;
      if (done !== 1'b1 || got.size() != 0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL len0: got done=%b beats=%0d busy=%b v=%b required 1/0/0/0",
                  done, got.size(), busy, m_axis_tvalid);
      end
   endtask

   task automatic test_areset_midburst();
      int guard;
      do_reset();
      m_axis_tready = 1'b1;
      do_update(32'h0100_0000, 32'h0, 16'd20, 1'b1, 1'b1);
      guard = 0;
      while (got.size() < 3 && guard < 20) begin
         clk_step();
         guard++;
      end
      #2;
      ARESET = 1'b1;
      #1;
      n_tests++;
      if ({m_axis_tvalid, m_axis_tlast, busy, done} !== 4'b0000 || m_axis_tdata !== 16'h0 || sample_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL areset_async: got v/l/busy/done=%b d=%h cnt=%0d required 0000/0/0",
                  {m_axis_tvalid, m_axis_tlast, busy, done}, m_axis_tdata, sample_cnt);
      end
      @(negedge ACLK);
      ARESET = 1'b0;
      got.delete();
      repeat (6) clk_step();
      n_tests++;
      if (got.size() != 0 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_quiet: got beats=%0d v=%b busy=%b required 0/0/0", got.size(), m_axis_tvalid, busy);
      end
   endtask

   task automatic test_random_run();
      logic [31:0] ftw;
      logic [31:0] poff;
      int          guard;
      int          bad;
      do_reset();
      ftw  = $urandom;
      poff = $urandom;
      do_update(ftw, poff, 16'd0, 1'b1, 1'b0);
      guard = 0;
      while (got.size() < 40 && guard < 400) begin
         m_axis_tready = ($urandom_range(0, 3) != 0);
         clk_step();
         guard++;
      end
      n_tests++;
      if (got.size() < 40) begin
         n_fail++;
         $display("FAIL rnd_run_timeout: got %0d beats required 40", got.size());
      end
      bad = 0;
      for (int i = 0; i < got.size(); i++) begin
         if (got[i].d !== ref_phase(ftw, poff, i) || got[i].l !== 1'b0) begin
            if (bad == 0) $display("FAIL rnd_run_beat%0d: got d=%h l=%b required %h/0",
                                   i, got[i].d, got[i].l, ref_phase(ftw, poff, i));
            bad++;
         end
      end
      n_tests++;
      if (bad != 0) n_fail++;
      n_tests++;
      if (sample_cnt !== 16'(got.size() + (m_axis_tvalid ? 1 : 0))) begin
         n_fail++;
         $display("FAIL rnd_run_cnt: got %0d required %0d", sample_cnt, got.size() + (m_axis_tvalid ? 1 : 0));
      end
   endtask

   task automatic test_random_burst();
      logic [31:0] ftw;
      logic [31:0] poff;
      logic [15:0] len;
      int          guard;
      int          bad;
      for (int it = 0; it < 4; it++) begin
         do_reset();
         ftw  = $urandom;
         poff = $urandom;
         len  = 16'($urandom_range(1, 12));
         do_update(ftw, poff, len, 1'b1, 1'b1);
         guard = 0;
         while (done !== 1'b1 && guard < 300) begin
            m_axis_tready = ($urandom_range(0, 2) != 0);
            clk_step();
            guard++;
         end
         m_axis_tready = 1'b1;
         repeat (3) clk_step();
         n_tests++;
         if (got.size() != int'(len) || done !== 1'b1 || busy !== 1'b0 || sample_cnt !== len) begin
            n_fail++;
            $display("FAIL rnd_burst%0d_end: got beats=%0d done=%b busy=%b cnt=%0d required %0d/1/0/%0d",
                     it, got.size(), done, busy, sample_cnt, len, len);
         end
         bad = 0;
         for (int i = 0; i < got.size(); i++) begin
            if (got[i].d !== ref_phase(ftw, poff, i) || got[i].l !== (i == int'(len) - 1)) bad++;
         end
         n_tests++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL rnd_burst%0d_beats: got %0d wrong beats required 0", it, bad);
         end
      end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_offset_retune();
      test_burst();
      test_backpressure();
      test_clear_stalled();
      test_burst_len0();
      test_areset_midburst();
      test_random_run();
      test_random_burst();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
